servo_pwm_ramp: RTL and testbench
=================================

Name: servo_pwm_ramp

Overview:
Downstream stage of the line-follower direction controller: converts the registered 2-bit servo direction command into two 50 Hz servo PWM pulse trains for a differential-drive pair of continuous-rotation servos. Pulse widths slew toward their targets by a bounded step per frame, so direction reversals do not jerk the chassis. Drives the board servo pins directly.

Parameters:
PERIOD_CYCLES, 2000000, PWM frame length in clk cycles (20 ms at 100 MHz)
PW_MIN, 100000, full-speed pulse width, mirrored direction (1.0 ms)
PW_MID, 150000, stop pulse width (1.5 ms)
PW_MAX, 200000, full-speed pulse width, forward direction (2.0 ms)
RAMP_STEP, 5000, maximum pulse-width change per frame, in cycles
CNT_W, 21, width of frame counter and pulse-width registers; must hold PERIOD_CYCLES-1

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
servo_direction  input  2  command: 00 rest, 01 left, 11 right, 10 treated as rest
servo  output  2  PWM outputs; [0] left-side servo, [1] right-side servo (mirrored mount)
frame_tick  output  1  one-cycle pulse on the frame-wrap cycle
settled  output  1  1 when both pulse widths equal their current targets

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, pw[0]=pw[1]=PW_MID, cmd_q=00, servo=00, frame_tick=0, settled=1. Takes effect without a clock edge, including mid-pulse.
- Frame counter cnt counts 0..PERIOD_CYCLES-1 and wraps to 0. The wrap cycle is the cycle with cnt==PERIOD_CYCLES-1.
- frame_tick is registered. It is 1 for exactly the one cycle after the wrap cycle, i.e. aligned with cnt==0.
- Command sampling: servo_direction is sampled only on the wrap cycle into cmd_q. Changes between wrap cycles have no effect.
- Target table, evaluated from the value being sampled:
  - rest / 10: tgt0=PW_MID, tgt1=PW_MID
  - left (01): tgt0=PW_MID, tgt1=PW_MIN
  - right (11): tgt0=PW_MAX, tgt1=PW_MID
- Ramp: on the wrap cycle, for each channel i:
  - if |tgt_i - pw[i]| <= RAMP_STEP, pw[i] <= tgt_i
  - else pw[i] moves RAMP_STEP toward tgt_i
  - Unsigned compare with no wrap-around; pw never leaves [PW_MIN, PW_MAX].
- New pw values apply from cnt=0 of the next frame.
- PWM output: servo[i] is registered from (cnt < pw[i]). Output lags cnt by one cycle and is high for exactly pw[i] consecutive cycles per frame. Rising edge occurs one cycle after cnt==0.
- settled is registered. It equals (pw[0]==tgt0 && pw[1]==tgt1) for the targets of cmd_q, and updates on the cycle after the wrap.
- Reset release: the first frame starts at cnt=0 on the first clock edge with rst=1. Outputs are MID-width pulses until a command is sampled.
- Integrity constraints (simulation assertion, not synthesised): PW_MIN < PW_MID < PW_MAX < PERIOD_CYCLES, and RAMP_STEP > 0.
- No combinational path from any input to any output.

Test Plan:
Simulation parameters for all scenarios: PERIOD_CYCLES=1000, PW_MIN=100, PW_MID=150, PW_MAX=200, RAMP_STEP=20, CNT_W=10.
1. Hold rst=0 for 5 cycles, then release with dir=00 -> servo=00 and frame_tick=0 during reset. Afterwards both channels are high for 150 cycles every 1000; frame_tick period is 1000; settled=1.
2. dir=11 held from the first frame -> servo[0] widths 170, 190, 200, 200; servo[1] stays 150. settled is 0 until the frame where servo[0] reaches 200, then 1.
3. From settled right, set dir=01 -> servo[0] widths 180, 160, 150; servo[1] widths 130, 110, 100. settled=1 only after both reach target.
4. dir pulsed 00->11->00 entirely between two wrap cycles -> no pulse-width change and settled stays 1.
5. dir=10 held -> behaves exactly as 00: both channels ramp to or hold 150.
6. Assert rst=0 mid-pulse (cnt=50, servo=11) -> servo=00 immediately, without a clock edge. After release, widths are back to 150 and settled=1.

Source files
------------

// File: rtl/servo_pwm_ramp.sv
// Two-channel 50 Hz servo PWM generator with per-frame slew limiting.
// The direction command is sampled once per frame. Pulse widths step toward
// the targets for that command by at most RAMP_STEP each frame. Every output
// is registered, so there is no combinational path from an input.
module servo_pwm_ramp #(
   parameter int unsigned PERIOD_CYCLES = 2000000,
   parameter int unsigned PW_MIN        = 100000,
   parameter int unsigned PW_MID        = 150000,
   parameter int unsigned PW_MAX        = 200000,
   parameter int unsigned RAMP_STEP     = 5000,
   parameter int unsigned CNT_W         = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] servo_direction,
   output logic [1:0] servo,
   output logic       frame_tick,
   output logic       settled
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PwMin   = CNT_W'(PW_MIN);
   localparam logic [CNT_W-1:0] PwMid   = CNT_W'(PW_MID);
   localparam logic [CNT_W-1:0] PwMax   = CNT_W'(PW_MAX);
   localparam logic [CNT_W-1:0] Step    = CNT_W'(RAMP_STEP);

   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [1:0][CNT_W-1:0]     pw_q, pw_d;
   logic [1:0][CNT_W-1:0]     tgt_new, tgt_d;
   logic [1:0]                cmd_q, cmd_d;
   logic [1:0]                servo_q, servo_d;
   logic                      frame_tick_q, settled_q, settled_d;
   logic                      wrap;

   // Target widths per command; [0] left servo, [1] right servo (mirrored).
   function automatic logic [1:0][CNT_W-1:0] targets(input logic [1:0] cmd);
      logic [1:0][CNT_W-1:0] t;
      case (cmd)
         2'b01:   begin t[0] = PwMid; t[1] = PwMin; end
         2'b11:   begin t[0] = PwMax; t[1] = PwMid; end
         default: begin t[0] = PwMid; t[1] = PwMid; end
      endcase
      return t;
   endfunction

   // One slew step toward tgt; unsigned differences taken in the safe order.
   function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                             input logic [CNT_W-1:0] tgt);
      if (tgt >= cur) begin
         return ((tgt - cur) <= Step) ? tgt : cur + Step;
      end else begin
         return ((cur - tgt) <= Step) ? tgt : cur - Step;
      end
   endfunction

   // Next-state: frame counter, command sampling, ramp and registered outputs.
   always_comb begin
      wrap      = (cnt_q == LastCnt);
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      tgt_new   = targets(servo_direction);
      cmd_d     = cmd_q;
      pw_d      = pw_q;
      if (wrap) begin
         cmd_d   = servo_direction;
         pw_d[0] = ramp(pw_q[0], tgt_new[0]);
         pw_d[1] = ramp(pw_q[1], tgt_new[1]);
      end
      tgt_d      = targets(cmd_d);
      // Only changes at the wrap edge, so it becomes visible with frame_tick.
      settled_d  = (pw_d[0] == tgt_d[0]) && (pw_d[1] == tgt_d[1]);
      servo_d[0] = (cnt_q < pw_q[0]);
      servo_d[1] = (cnt_q < pw_q[1]);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         pw_q[0]      <= PwMid;
         pw_q[1]      <= PwMid;
         cmd_q        <= 2'b00;
         servo_q      <= 2'b00;
         frame_tick_q <= 1'b0;
         settled_q    <= 1'b1;
      end else begin
         cnt_q        <= cnt_d;
         pw_q         <= pw_d;
         cmd_q        <= cmd_d;
         servo_q      <= servo_d;
         frame_tick_q <= wrap;
         settled_q    <= settled_d;
      end
   end

   // Parameter sanity check; immediate assertion, ignored by synthesis.
   always_ff @(posedge clk) begin
      assert ((PW_MIN < PW_MID) && (PW_MID < PW_MAX) && (PW_MAX < PERIOD_CYCLES) &&
              (RAMP_STEP > 0))
         else $error("servo_pwm_ramp: inconsistent pulse-width parameters");
   end

   assign servo      = servo_q;
   assign frame_tick = frame_tick_q;
   assign settled    = settled_q;

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Scoreboard bench for servo_pwm_ramp: the stimulus pushes the expected width
// and settled value of each frame; a monitor measures every finished frame.
module tb_servo_pwm_ramp;

   localparam int PERIOD = 1000;
   localparam int PMIN   = 100;
   localparam int PMID   = 150;
   localparam int PMAX   = 200;
   localparam int STEP   = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dir = 2'b00;
   logic [1:0] servo;
   logic       frame_tick;
   logic       settled;

   servo_pwm_ramp #(
      .PERIOD_CYCLES (PERIOD),
      .PW_MIN        (PMIN),
      .PW_MID        (PMID),
      .PW_MAX        (PMAX),
      .RAMP_STEP     (STEP),
      .CNT_W         (10)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .servo_direction (dir),
      .servo           (servo),
      .frame_tick      (frame_tick),
      .settled         (settled)
   );

   always #5 clk = ~clk;

   typedef struct {
      int w0;
      int w1;
      int st;
   } frame_t;

   frame_t exp_q[$];
   int     vectors    = 0;
   int     miscompares = 0;
   int     m_pw0      = PMID;
   int     m_pw1      = PMID;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: move at most STEP toward the target, land on it when close.
   function automatic int toward(input int cur, input int tgt);
      if (tgt - cur > STEP) return cur + STEP;
      if (cur - tgt > STEP) return cur - STEP;
      return tgt;
   endfunction

   task automatic model_frame(input logic [1:0] d);
      int t0, t1;
      frame_t e;
      case (d)
         2'b01:   begin t0 = PMID; t1 = PMIN; end
         2'b11:   begin t0 = PMAX; t1 = PMID; end
         default: begin t0 = PMID; t1 = PMID; end
      endcase
      m_pw0 = toward(m_pw0, t0);
      m_pw1 = toward(m_pw1, t1);
      e.w0 = m_pw0;
      e.w1 = m_pw1;
      e.st = (m_pw0 == t0 && m_pw1 == t1) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 3 * PERIOD);
      if (!frame_tick) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_tick_timeout: got none in %0d cycles, expected one", n);
      end
   endtask

   // Called at the start of a frame; the final dir value is what gets sampled.
   task automatic run_frame(input logic [1:0] d, input bit glitch, input logic [1:0] gval);
      if (glitch) begin
         dir = gval;
         repeat (100) @(negedge clk);
      end
      dir = d;
      model_frame(d);
      wait_tick();
   endtask

   task automatic release_reset();
      exp_q.delete();
      m_pw0 = PMID;
      m_pw1 = PMID;
      exp_q.push_back('{w0: PMID, w1: PMID, st: 1});
      #1 rst = 1'b1;
   endtask

   // Monitor: count high cycles per frame, compare against the scoreboard.
   int hi0, hi1, cyc, last_st;
   bit first;
   frame_t got_e;
   always @(negedge clk) begin
      if (!rst) begin
         hi0 = 0; hi1 = 0; cyc = 0; first = 1'b1;
      end else begin
         if (frame_tick) begin
            if (!first) check("frame_period", cyc, PERIOD);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL scoreboard_underflow: got a frame, expected none queued");
            end else begin
               got_e = exp_q.pop_front();
               check("width_servo0", hi0, got_e.w0);
               check("width_servo1", hi1, got_e.w1);
               check("settled", last_st, got_e.st);
            end
            first = 1'b0;
            hi0 = 0; hi1 = 0; cyc = 0;
         end
         cyc++;
         hi0 += int'(servo[0]);
         hi1 += int'(servo[1]);
         last_st = int'(settled);
      end
   end

   initial begin
      logic [1:0] d, gv;
      bit g;
      #1 rst = 1'b0;
      // Reset state
      repeat (5) begin
         @(negedge clk);
         check("rst_servo", servo, 0);
         check("rst_frame_tick", frame_tick, 0);
         check("rst_settled", settled, 1);
      end
      release_reset();

      // Rest, then ramp right, then reverse to left
      run_frame(2'b00, 1'b0, 2'b00);
      repeat (4) run_frame(2'b11, 1'b0, 2'b00);
      repeat (4) run_frame(2'b01, 1'b0, 2'b00);
      repeat (4) run_frame(2'b00, 1'b0, 2'b00);
      // Command glitch between wraps must be ignored
      repeat (2) run_frame(2'b00, 1'b1, 2'b11);
      // 10 behaves as rest
      repeat (2) run_frame(2'b11, 1'b0, 2'b00);
      repeat (3) run_frame(2'b10, 1'b0, 2'b00);

      // Randomized commands with random intra-frame glitches
      for (int i = 0; i < 20; i++) begin
         d  = 2'($urandom_range(0, 3));
         gv = 2'($urandom_range(0, 3));
         g  = 1'($urandom_range(0, 1));
         run_frame(d, g, gv);
      end

      // Asynchronous reset mid-pulse, away from settled
      dir = 2'b00;
      repeat (2) run_frame(2'b00, 1'b0, 2'b00);
      repeat (2) run_frame(2'b11, 1'b0, 2'b00);
      repeat (50) @(negedge clk);
      check("midpulse_servo", servo, 3);
      check("midpulse_settled_before", settled, 0);
      dir = 2'b00;
      #1 rst = 1'b0;
      #1;
      check("async_rst_servo", servo, 0);
      check("async_rst_frame_tick", frame_tick, 0);
      check("async_rst_settled", settled, 1);
      repeat (3) @(negedge clk);
      release_reset();
      repeat (2) run_frame(2'b00, 1'b0, 2'b00);
      wait_tick();
      @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
